// File: rtl/tawas_rcn_wb.sv
// ============================================================================
// tawas_rcn_wb : load-return writeback queue feeding the regfile rcn_load port.
// Optional zero-latency bypass when TAWAS_RCN_WB_BYPASS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tawas_rcn_wb #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld_i,
  input  logic [1:0]  req_slice_i,
  input  logic        rsp_vld_i,
  output logic        rsp_rdy_o,
  input  logic [1:0]  rsp_slice_i,
  input  logic [2:0]  rsp_sel_i,
  input  logic [31:0] rsp_data_i,
  input  logic [3:0]  wb_hold_i,
  output logic        rcn_load_vld_o,
  output logic [1:0]  rcn_load_slice_o,
  output logic [2:0]  rcn_load_sel_o,
  output logic [31:0] rcn_load_o,
  output logic [3:0]  ld_busy_o,
  output logic [3:0]  ld_full_o,
  output logic        err_o
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       slice_q [DEPTH];
  logic [2:0]       sel_q   [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic             err_q, err_d;

  logic             w_full, w_empty, w_push, w_issue, w_byp;
  logic [1:0]       w_head_slice;
  logic [3:0]       w_inc, w_dec;

  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_empty = (wr_ptr_q == rd_ptr_q);

  assign w_head_slice = slice_q[rd_ptr_q[AW-1:0]];
  assign w_issue      = !rst && !w_empty && !wb_hold_i[w_head_slice];

`ifdef TAWAS_RCN_WB_BYPASS_EN
  assign w_byp = !rst && w_empty && rsp_vld_i && !wb_hold_i[rsp_slice_i];
`else
  assign w_byp = 1'b0;
`endif

  assign rsp_rdy_o = !rst && !w_full;
  assign w_push    = rsp_vld_i && rsp_rdy_o && !w_byp;

  // Head-of-line order: the FIFO head always wins; bypass only runs when empty.
  always_comb begin
    rcn_load_vld_o   = 1'b0;
    rcn_load_slice_o = 2'd0;
    rcn_load_sel_o   = 3'd0;
    rcn_load_o       = 32'd0;
    if (w_issue) begin
      rcn_load_vld_o   = 1'b1;
      rcn_load_slice_o = w_head_slice;
      rcn_load_sel_o   = sel_q[rd_ptr_q[AW-1:0]];
      rcn_load_o       = data_q[rd_ptr_q[AW-1:0]];
    end else if (w_byp) begin
      rcn_load_vld_o   = 1'b1;
      rcn_load_slice_o = rsp_slice_i;
      rcn_load_sel_o   = rsp_sel_i;
      rcn_load_o       = rsp_data_i;
    end
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_slice
      assign w_inc[g]     = req_vld_i && (req_slice_i == 2'(g));
      assign w_dec[g]     = rcn_load_vld_o && (rcn_load_slice_o == 2'(g));
      assign ld_busy_o[g] = (cnt_q[g] != '0);
      assign ld_full_o[g] = (cnt_q[g] == CNT_MAX);
    end
  endgenerate

  // Counters saturate at both ends; any clipped step flags the sticky error.
  always_comb begin
    err_d = err_q;
    if (rsp_vld_i && w_full) err_d = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cnt_d[s] = cnt_q[s];
      if (w_inc[s] && !w_dec[s]) begin
        if (cnt_q[s] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[s] = cnt_q[s] + 1'b1;
      end else if (w_dec[s] && !w_inc[s]) begin
        if (cnt_q[s] == '0) err_d = 1'b1;
        else                cnt_d[s] = cnt_q[s] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int s = 0; s < 4; s++) cnt_q[s] <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      err_q <= err_d;
      for (int s = 0; s < 4; s++) cnt_q[s] <= cnt_d[s];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      slice_q[wr_ptr_q[AW-1:0]] <= rsp_slice_i;
      sel_q[wr_ptr_q[AW-1:0]]   <= rsp_sel_i;
      data_q[wr_ptr_q[AW-1:0]]  <= rsp_data_i;
    end
  end

  assign err_o = err_q;

endmodule

`default_nettype wire
